// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - enqueue/dequeue handshake bundle for the fetch queue
interface fetch_queue_if;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;

  // Environment side: IF stage drives enq, decode drives deq_ready
  modport master (
    output enq_valid, enq_pc, enq_instr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr
  );

  // Queue side
  modport slave (
    input  enq_valid, enq_pc, enq_instr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - {pc, instr} buffer between the PC/IF stage and decode
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  fetch_queue_if.slave  q,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef logic [63:0] entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          enq_fire, deq_fire;

  // Status comes from held state only, so PCEN never sees deq_ready or flush
  assign q.enq_ready = (cnt_q != FULL_CNT);
  assign q.deq_valid = (cnt_q != '0);
  assign q.deq_pc    = q.deq_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
  assign q.deq_instr = q.deq_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign count       = cnt_q;

  // Flush dominates: a redirect cancels any transfer in the same cycle
  assign enq_fire = q.enq_valid & q.enq_ready & ~flush;
  assign deq_fire = q.deq_valid & q.deq_ready & ~flush;

  // Next pointer/count/storage values
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq_fire) begin
        mem_d[wr_ptr_q] = {q.enq_pc, q.enq_instr};
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (enq_fire && !deq_fire) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (deq_fire && !enq_fire) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random checks of fetch_queue against a queue model
module tb_fetch_queue;
  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  int         n_checks;
  int         n_errors;
  logic [63:0] model_q[$];
  bit          seq_chk;
  logic [31:0] last_deq_pc;
  bit          have_last;

  fetch_queue_if fq_if ();

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (fq_if),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return ~pc ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model queue
  task automatic check_model(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".enq_ready"}, 32'(fq_if.enq_ready), 32'(sz < 4));
    chk({tag, ".deq_valid"}, 32'(fq_if.deq_valid), 32'(sz > 0));
    chk({tag, ".deq_pc"}, fq_if.deq_pc, (sz > 0) ? model_q[0][63:32] : 32'h0);
    chk({tag, ".deq_instr"}, fq_if.deq_instr, (sz > 0) ? model_q[0][31:0] : 32'h0);
  endtask

  // One clock: drive after the falling edge, check, then apply the model at the rising edge
  task automatic step(input string tag, input bit fl, input bit ev, input logic [31:0] pc,
                      input logic [31:0] instr, input bit dr);
    bit ef, df;
    logic [63:0] popped;
    flush           = fl;
    fq_if.enq_valid = ev;
    fq_if.enq_pc    = pc;
    fq_if.enq_instr = instr;
    fq_if.deq_ready = dr;
    #1;
    check_model(tag);
    ef = ev && (model_q.size() < 4) && !fl;
    df = dr && (model_q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (df) begin
        popped = model_q.pop_front();
        if (seq_chk && have_last) chk({tag, ".order"}, popped[63:32], last_deq_pc + 32'd4);
        last_deq_pc = popped[63:32];
        have_last   = 1'b1;
      end
      if (ef) model_q.push_back({pc, instr});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    flush           = 1'b0;
    fq_if.enq_valid = 1'b0;
    fq_if.deq_ready = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    seq_chk  = 1'b0;
    have_last = 1'b0;
    last_deq_pc = '0;
    reset = 1'b0;
    flush = 1'b0;
    fq_if.enq_valid = 1'b0;
    fq_if.enq_pc    = '0;
    fq_if.enq_instr = '0;
    fq_if.deq_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_model("reset");
    reset = 1'b1;
    @(negedge clk);

    // Empty: enqueued pair is not visible until after the edge
    step("t6_enq", 0, 1, 32'h3000, instr_of(32'h3000), 1);
    idle();
    chk("t6_deq_valid", 32'(fq_if.deq_valid), 32'd1);
    chk("t6_deq_pc", fq_if.deq_pc, 32'h3000);

    // Fill to DEPTH; the fifth enqueue is held off
    for (int i = 1; i < 4; i++)
      step("t2_fill", 0, 1, 32'h3000 + 32'(4 * i), instr_of(32'h3000 + 32'(4 * i)), 0);
    idle();
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_enq_ready", 32'(fq_if.enq_ready), 32'd0);
    chk("t2_deq_instr", fq_if.deq_instr, instr_of(32'h3000));
    step("t2_hold", 0, 1, 32'h3010, instr_of(32'h3010), 0);

    // Full with deq_ready: first edge only dequeues, second does both
    step("t3_e1", 0, 1, 32'h3010, instr_of(32'h3010), 1);
    idle();
    chk("t3_e1_count", 32'(count), 32'd3);
    step("t3_e2", 0, 1, 32'h3010, instr_of(32'h3010), 1);
    idle();
    chk("t3_e2_count", 32'(count), 32'd3);
    chk("t3_e2_head", fq_if.deq_pc, 32'h3008);

    // Drain to two then stream enq+deq for ten cycles across pointer wraps
    step("t4_trim", 0, 0, 32'h0, 32'h0, 1);
    seq_chk = 1'b1;
    for (int i = 0; i < 10; i++)
      step("t4_stream", 0, 1, 32'h3014 + 32'(4 * i), instr_of(32'h3014 + 32'(4 * i)), 1);
    seq_chk = 1'b0;
    idle();
    chk("t4_count", 32'(count), 32'd2);
    chk("t4_head", fq_if.deq_pc, 32'h3034);

    // Flush dominates a simultaneous enq and deq
    step("t5_pre", 0, 1, 32'h303c, instr_of(32'h303c), 0);
    step("t5_flush", 1, 1, 32'h5000, instr_of(32'h5000), 1);
    idle();
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_deq_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("t5_enq_ready", 32'(fq_if.enq_ready), 32'd1);
    step("t5_enq", 0, 1, 32'h4000, instr_of(32'h4000), 0);
    idle();
    chk("t5_head", fq_if.deq_pc, 32'h4000);

    // Asynchronous reset mid-cycle with three entries held
    step("t1_a", 0, 1, 32'h4004, instr_of(32'h4004), 0);
    step("t1_b", 0, 1, 32'h4008, instr_of(32'h4008), 0);
    idle();
    chk("t1_pre_count", 32'(count), 32'd3);
    reset = 1'b0;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_deq_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("t1_enq_ready", 32'(fq_if.enq_ready), 32'd1);
    chk("t1_deq_pc", fq_if.deq_pc, 32'h0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      step("rnd", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, rpc, $urandom,
           $urandom_range(0, 2) != 0);
    end
    idle();
    check_model("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
